// File: rtl/sp_ram_banked.sv
// Banked single-port synchronous RAM with registered bank-select mux, optional output
// pipeline stage, selectable write/read collision behaviour and a post-reset clear sequencer.
module sp_ram_banked #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_W         = 15,
  parameter int unsigned BANK_AW        = 14,
  parameter int unsigned READ_MODE      = 0,
  parameter int unsigned WRITE_MODE     = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ce,
  input  logic              i_oce,
  input  logic              i_wre,
  input  logic [ADDR_W-1:0] i_ad,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_dout_valid,
  output logic              o_ready
);

  localparam int unsigned NBankBits = ADDR_W - BANK_AW;
  localparam int unsigned NumBanks  = 1 << NBankBits;
  localparam int unsigned BankDepth = 1 << BANK_AW;
  localparam int unsigned BSelW     = (NBankBits > 0) ? NBankBits : 1;

  localparam logic [0:0] StClear = 1'b0;
  localparam logic [0:0] StRun   = 1'b1;

  localparam logic [0:0] StInit    = (CLEAR_ON_RESET != 0) ? StClear : StRun;
  localparam logic       ReadyInit = (CLEAR_ON_RESET == 0);

  if (ADDR_W < BANK_AW || READ_MODE > 1 || WRITE_MODE > 2) begin : g_bad_params
    $error("sp_ram_banked: unsupported parameter combination");
  end

  logic [DATA_W-1:0] r_mem [NumBanks][BankDepth];

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_clr_addr;
  logic              r_ready;

  logic [DATA_W-1:0] r_q1 [NumBanks];
  logic [BSelW-1:0]  r_bank;
  logic              r_v1;

  logic [BSelW-1:0]   w_ad_bank;
  logic [BSelW-1:0]   w_clr_bank;
  logic [BANK_AW-1:0] w_ad_lo;
  logic [BANK_AW-1:0] w_clr_lo;
  logic               w_clearing;
  logic               w_acc;
  logic               w_wr;
  logic               w_rd;
  logic               w_load_q1;
  logic               w_mem_we;
  logic [BSelW-1:0]   w_mem_bank;
  logic [BANK_AW-1:0] w_mem_lo;
  logic [DATA_W-1:0]  w_mem_data;
  logic [DATA_W-1:0]  w_mux;

  assign w_ad_lo  = i_ad[BANK_AW-1:0];
  assign w_clr_lo = r_clr_addr[BANK_AW-1:0];

  if (NBankBits > 0) begin : g_banked
    assign w_ad_bank  = i_ad[ADDR_W-1:BANK_AW];
    assign w_clr_bank = r_clr_addr[ADDR_W-1:BANK_AW];
    assign w_mux      = r_q1[r_bank];
  end else begin : g_single
    assign w_ad_bank  = '0;
    assign w_clr_bank = '0;
    assign w_mux      = r_q1[0];
  end

  assign w_clearing = (r_state == StClear);
  assign w_acc      = i_ce & r_ready;
  assign w_wr       = w_acc & i_wre;
  assign w_rd       = w_acc & ~i_wre;
  // Mode 0 writes leave the output path untouched; modes 1/2 produce data like a read.
  assign w_load_q1  = w_rd | (w_wr & (WRITE_MODE != 0));

  always_comb begin
    w_mem_we   = ~i_reset & (w_clearing | w_wr);
    w_mem_bank = w_ad_bank;
    w_mem_lo   = w_ad_lo;
    w_mem_data = i_din;
    if (w_clearing) begin
      w_mem_bank = w_clr_bank;
      w_mem_lo   = w_clr_lo;
      w_mem_data = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_bank][w_mem_lo] <= w_mem_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= StInit;
      r_clr_addr <= '0;
      r_ready    <= ReadyInit;
    end else if (r_state == StClear) begin
      r_clr_addr <= r_clr_addr + 1'b1;
      if (&r_clr_addr) begin
        r_state <= StRun;
        r_ready <= 1'b1;
      end
    end
  end

  // Every bank is read in parallel; the registered bank index picks the result a cycle later.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned b = 0; b < NumBanks; b++) begin
        r_q1[b] <= '0;
      end
      r_bank <= '0;
      r_v1   <= 1'b0;
    end else begin
      r_v1 <= 1'b0;
      if (w_load_q1) begin
        r_bank <= w_ad_bank;
        r_v1   <= 1'b1;
        for (int unsigned b = 0; b < NumBanks; b++) begin
          if (w_wr && (WRITE_MODE == 1) && (w_ad_bank == BSelW'(b))) begin
            r_q1[b] <= i_din;
          end else begin
            r_q1[b] <= r_mem[b][w_ad_lo];
          end
        end
      end
    end
  end

  if (READ_MODE == 1) begin : g_pipe
    logic [DATA_W-1:0] r_q2;
    logic              r_v2;

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        r_q2 <= '0;
        r_v2 <= 1'b0;
      end else if (i_oce) begin
        r_q2 <= w_mux;
        r_v2 <= r_v1;
      end else begin
        r_v2 <= 1'b0;
      end
    end

    assign o_dout       = r_q2;
    assign o_dout_valid = r_v2;
  end else begin : g_bypass
    logic w_unused_oce;
    assign w_unused_oce = i_oce;
    assign o_dout       = w_mux;
    assign o_dout_valid = r_v1;
  end

  assign o_ready = r_ready;

endmodule

// File: tb/tb_sp_ram_banked.sv
// Randomised and directed bench for sp_ram_banked: six small configurations checked against a
// behavioural model every cycle, plus a default-size and a single-bank instance checked directly.
module tb_sp_ram_banked;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Small family: k = READ_MODE*3 + WRITE_MODE, all 16x8 in two banks.
  logic       s_rst = 1'b1, s_ce = 1'b0, s_oce = 1'b0, s_wre = 1'b0;
  logic [3:0] s_ad = '0;
  logic [7:0] s_din = '0;
  logic [7:0] s_dout [6];
  logic       s_valid [6];
  logic       s_ready [6];

  for (genvar k = 0; k < 6; k++) begin : g_small
    sp_ram_banked #(
      .DATA_W(8), .ADDR_W(4), .BANK_AW(3),
      .READ_MODE(k / 3), .WRITE_MODE(k % 3), .CLEAR_ON_RESET(1)
    ) u_dut (
      .i_clk(clk), .i_reset(s_rst), .i_ce(s_ce), .i_oce(s_oce), .i_wre(s_wre),
      .i_ad(s_ad), .i_din(s_din),
      .o_dout(s_dout[k]), .o_dout_valid(s_valid[k]), .o_ready(s_ready[k])
    );
  end

  // Default-size instance and a single-bank instance without clear.
  logic        d_rst = 1'b1, d_ce = 1'b0, d_oce = 1'b0, d_wre = 1'b0;
  logic [14:0] d_ad = '0;
  logic [7:0]  d_din = '0, d_dout;
  logic        d_valid, d_ready;

  sp_ram_banked u_def (
    .i_clk(clk), .i_reset(d_rst), .i_ce(d_ce), .i_oce(d_oce), .i_wre(d_wre),
    .i_ad(d_ad), .i_din(d_din), .o_dout(d_dout), .o_dout_valid(d_valid), .o_ready(d_ready)
  );

  logic       b_ce = 1'b0, b_wre = 1'b0;
  logic [2:0] b_ad = '0;
  logic [7:0] b_din = '0, b_dout;
  logic       b_valid, b_ready;

  sp_ram_banked #(
    .DATA_W(8), .ADDR_W(3), .BANK_AW(3), .READ_MODE(0), .WRITE_MODE(0), .CLEAR_ON_RESET(0)
  ) u_sb (
    .i_clk(clk), .i_reset(d_rst), .i_ce(b_ce), .i_oce(1'b0), .i_wre(b_wre),
    .i_ad(b_ad), .i_din(b_din), .o_dout(b_dout), .o_dout_valid(b_valid), .o_ready(b_ready)
  );

  // Behavioural model: memory array, cycles since reset, and the last value each
  // configuration produced (e1) and, for pipelined ones, what the output stage holds (e2).
  logic [7:0] m_mem [16];
  int         m_cnt;
  logic [7:0] e1 [6], e2 [6];
  bit         ev1 [6], ev2 [6];
  bit         m_rdy, m_acc, m_prod;
  logic [7:0] m_old, m_val;

  always begin
    @(posedge clk);
    if (s_rst) begin
      m_cnt = 0;
      for (int k = 0; k < 6; k++) begin
        e1[k] = '0; e2[k] = '0; ev1[k] = 1'b0; ev2[k] = 1'b0;
      end
    end else begin
      m_rdy = (m_cnt >= 16);
      m_acc = s_ce && m_rdy;
      m_old = m_mem[s_ad];
      for (int k = 0; k < 6; k++) begin
        if (k >= 3) begin
          if (s_oce) begin
            e2[k] = e1[k]; ev2[k] = ev1[k];
          end else begin
            ev2[k] = 1'b0;
          end
        end
        m_prod = 1'b0;
        m_val  = m_old;
        if (m_acc && !s_wre) m_prod = 1'b1;
        if (m_acc && s_wre && (k % 3) == 1) begin m_prod = 1'b1; m_val = s_din; end
        if (m_acc && s_wre && (k % 3) == 2) m_prod = 1'b1;
        if (m_prod) e1[k] = m_val;
        ev1[k] = m_prod;
      end
      if (m_acc && s_wre) m_mem[s_ad] = s_din;
      if (!m_rdy) begin
        if (m_cnt == 15) for (int a = 0; a < 16; a++) m_mem[a] = '0;
        m_cnt++;
      end
    end
    #1;
    if (!s_rst) begin
      for (int k = 0; k < 6; k++) begin
        chk($sformatf("model_dout_k%0d", k), s_dout[k], (k >= 3) ? e2[k] : e1[k]);
        chk($sformatf("model_valid_k%0d", k), s_valid[k], (k >= 3) ? ev2[k] : ev1[k]);
        chk($sformatf("model_ready_k%0d", k), s_ready[k], (m_cnt >= 16) ? 1 : 0);
      end
    end
  end

  task automatic sdrive(input bit ce, input bit oce, input bit wre, input int ad, input int din);
    @(negedge clk);
    s_ce = ce; s_oce = oce; s_wre = wre; s_ad = 4'(ad); s_din = 8'(din);
  endtask

  task automatic stick();
    @(posedge clk);
    #2;
  endtask

  task automatic count_clear(input string name);
    int n;
    n = 0;
    do begin
      stick();
      n++;
    end while (!s_ready[0] && n < 100);
    chk(name, n, 16);
  endtask

  task automatic random_run(input int cycles);
    repeat (cycles) begin
      sdrive(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4),
             $urandom_range(0, 15), $urandom_range(0, 255));
      stick();
    end
  endtask

  task automatic small_seq();
    repeat (3) @(posedge clk);
    @(negedge clk);
    s_rst = 1'b0;
    #1 chk("ready_at_release", s_ready[0], 0);
    count_clear("clear_cycles");
    for (int a = 0; a < 16; a++) begin
      sdrive(1, 1, 0, a, 0);
      stick();
      chk("cleared_rd_dout", s_dout[0], 0);
      chk("cleared_rd_valid", s_valid[0], 1);
    end
    // Write-mode collision behaviour.
    sdrive(1, 1, 0, 3, 0);    stick();
    sdrive(1, 1, 1, 5, 8'h11); stick();
    sdrive(1, 1, 1, 5, 8'h22); stick();
    chk("wm0_dout_hold", s_dout[0], 0);
    chk("wm0_no_valid", s_valid[0], 0);
    chk("wm1_dout_new", s_dout[1], 8'h22);
    chk("wm1_valid", s_valid[1], 1);
    chk("wm2_dout_old", s_dout[2], 8'h11);
    chk("wm2_valid", s_valid[2], 1);
    // Output register gated by oce.
    sdrive(1, 1, 0, 5, 0); stick();
    sdrive(0, 1, 0, 0, 0); stick();
    chk("rm1_prior_dout", s_dout[3], 8'h22);
    chk("rm1_prior_valid", s_valid[3], 1);
    sdrive(1, 0, 1, 10, 8'h3C); stick();
    chk("rm1_wr_no_valid", s_valid[3], 0);
    repeat (3) begin
      sdrive(1, 0, 0, 10, 0); stick();
      chk("rm1_oce0_hold", s_dout[3], 8'h22);
      chk("rm1_oce0_valid", s_valid[3], 0);
    end
    sdrive(0, 1, 0, 0, 0); stick();
    chk("rm1_oce1_dout", s_dout[3], 8'h3C);
    chk("rm1_oce1_valid", s_valid[3], 1);
    sdrive(0, 1, 0, 0, 0); stick();
    chk("rm1_pulse_end", s_valid[3], 0);
    chk("rm1_dout_kept", s_dout[3], 8'h3C);
    // Write with ce low must not land.
    sdrive(1, 1, 1, 2, 8'h77); stick();
    sdrive(0, 1, 1, 2, 8'hFF); stick();
    chk("ce0_no_valid_wm1", s_valid[1], 0);
    chk("ce0_no_valid_wm0", s_valid[0], 0);
    sdrive(1, 1, 0, 2, 0); stick();
    chk("ce0_mem_kept", s_dout[0], 8'h77);
    random_run(1500);
    // Reset in the middle of the clear sequence.
    @(negedge clk);
    s_rst = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rst_dout_k%0d", k), s_dout[k], 0);
      chk($sformatf("rst_valid_k%0d", k), s_valid[k], 0);
      chk($sformatf("rst_ready_k%0d", k), s_ready[k], 0);
    end
    @(negedge clk);
    s_rst = 1'b0;
    repeat (7) stick();
    @(negedge clk);
    s_rst = 1'b1;
    #1 chk("midclr_rst_dout", s_dout[1], 0);
    chk("midclr_rst_ready", s_ready[1], 0);
    @(negedge clk);
    s_rst = 1'b0;
    count_clear("clear_restart_cycles");
    random_run(500);
  endtask

  task automatic ddrive(input bit ce, input bit wre, input int ad, input int din);
    @(negedge clk);
    d_ce = ce; d_oce = 1'b1; d_wre = wre; d_ad = 15'(ad); d_din = 8'(din);
  endtask

  task automatic default_seq();
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    d_rst = 1'b0;
    #1 chk("def_ready_at_release", d_ready, 0);
    chk("sb_ready_no_clear", b_ready, 1);
    n = 0;
    do begin
      stick();
      n++;
    end while (!d_ready && n < 40000);
    chk("def_clear_cycles", n, 32768);
    ddrive(1, 1, 15'h3FFF, 8'hA5); stick();
    chk("def_wr_no_valid", d_valid, 0);
    ddrive(1, 1, 15'h4000, 8'h5A); stick();
    ddrive(1, 0, 15'h3FFF, 0); stick();
    chk("def_rd0_dout", d_dout, 8'hA5);
    chk("def_rd0_valid", d_valid, 1);
    ddrive(1, 0, 15'h4000, 0); stick();
    chk("def_rd1_dout", d_dout, 8'h5A);
    chk("def_rd1_valid", d_valid, 1);
    ddrive(0, 0, 0, 0); stick();
    chk("def_idle_valid", d_valid, 0);
    chk("def_idle_dout", d_dout, 8'h5A);
    @(negedge clk);
    b_ce = 1'b1; b_wre = 1'b1; b_ad = 3'd6; b_din = 8'h5C;
    stick();
    @(negedge clk);
    b_wre = 1'b0;
    stick();
    chk("sb_rd_dout", b_dout, 8'h5C);
    chk("sb_rd_valid", b_valid, 1);
    @(negedge clk);
    b_ce = 1'b0;
    stick();
    chk("sb_idle_valid", b_valid, 0);
  endtask

  initial begin
    fork
      small_seq();
      default_seq();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
